// File: rtl/leg_uart_pkg.sv
// Shared definitions for the LEG UART receive and transmit paths.
package leg_uart_pkg;

  localparam int unsigned UART_DATA_BITS            = 8;
  localparam int unsigned UART_DEFAULT_CLKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// First-word fall-through synchronous FIFO shared by the UART rx and tx paths.
module uart_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign rdata   = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is still accepted when a pop frees the head slot this cycle.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchroniser, bit-timing FSM, shift register, receive FIFO and sticky error flags.
module uart_rx
  import leg_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overrun,
  input  logic       i_clear_err
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT = 3'(UART_DATA_BITS - 1);

  logic [1:0]                sync;
  logic                      rx_s;
  rx_state_t                 state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [2:0]                bit_q, bit_d;
  logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
  logic                      byte_push;
  logic                      frame_set;

  logic                      fifo_pop;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                      drop;

  assign rx_s = sync[1];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) sync <= '1;
    else       sync <= {sync[0], i_rx};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    byte_push = 1'b0;
    frame_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_CNT) begin
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            cnt_d   = '0;
            bit_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == FULL_CNT) begin
          shreg_d = {rx_s, shreg_q[UART_DATA_BITS-1:1]};
          cnt_d   = '0;
          bit_d   = bit_q + 3'd1;
          if (bit_q == LAST_BIT) state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == FULL_CNT) begin
          cnt_d = '0;
          if (rx_s) begin
            byte_push = 1'b1;
            state_d   = IDLE;
          end else begin
            frame_set = 1'b1;
            state_d   = BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BREAK: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign fifo_pop = i_ready & ~fifo_empty;
  assign o_valid  = (fifo_count != '0);
  // Full FIFO only loses the byte when no pop frees a slot in the same cycle.
  assign drop     = byte_push & fifo_full & ~fifo_pop;

  uart_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (byte_push),
    .wdata (shreg_q),
    .pop   (fifo_pop),
    .rdata (o_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      o_frame_err <= frame_set | (o_frame_err & ~i_clear_err);
      o_overrun   <= drop      | (o_overrun   & ~i_clear_err);
    end
  end

endmodule
